// File: rtl/multi_dataflow_job_sequencer_pkg.sv
// Shared types for the multi_dataflow job sequencer slice.
// Holds the job descriptor layout, the sequencer state encoding, the default
// widths, and the ctrl/flags bundles used for the hwpe-ctrl hookup.
package multi_dataflow_job_sequencer_pkg;

  localparam int unsigned JOB_DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned ID_W_DEF      = 4;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [CNT_W_DEF-1:0] len;
  } job_desc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic clear;
  } ctrl_sequencer_t;

  typedef struct packed {
    logic                 busy;
    logic                 evt_done;
    logic [ID_W_DEF-1:0]  done_id;
    logic [CNT_W_DEF-1:0] out_cnt;
  } flags_sequencer_t;

endpackage

// File: rtl/multi_dataflow_job_sequencer_if.sv
// Job descriptor handshake between the hwpe-ctrl side and the sequencer.
//   job_valid  descriptor valid (master -> slave)
//   job_ready  queue can accept (slave -> master)
//   job_id     job identifier
//   job_len    number of outputs the job produces
interface multi_dataflow_job_sequencer_if #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned CNT_W = 16
);
  logic             job_valid;
  logic             job_ready;
  logic [ID_W-1:0]  job_id;
  logic [CNT_W-1:0] job_len;

  modport master (output job_valid, output job_id, output job_len, input job_ready);
  modport slave  (input job_valid, input job_id, input job_len, output job_ready);
endinterface

// File: rtl/multi_dataflow_job_sequencer_fifo.sv
// Synchronous FIFO holding packed job descriptors {id, len}.
//   push_i/data_i   write side, ignored when full or during clear
//   pop_i/data_o    read side, data_o shows the head combinationally
//   full_o/empty_o  occupancy flags; level_o entry count
//   clear_i         synchronous flush, wins over push and pop
module multi_dataflow_job_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 20
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q;
  logic              do_push, do_pop;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full_o  = cnt_q[PTR_W];
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/multi_dataflow_job_sequencer.sv
// Queues job descriptors and issues one start pulse per job to the kernel
// adapter, counts its per-output done flags, and signals completion.
//   clk_i/rst_ni   clock, async active-low reset
//   clear_i        soft clear: flush queue, abort current job
//   job            descriptor handshake (slave side)
//   start_o        1-cycle start pulse per non-empty job
//   kdone_i        one pulse per produced output
//   busy_o         job in flight or queue non-empty
//   out_cnt_o      outputs counted for the current job
//   evt_done_o     1-cycle completion pulse, done_id_o holds the job id
//   queue_lvl_o    queue occupancy
//
// state  | meaning
// IDLE   | waiting for a queued job
// START  | start_o high this cycle; kdone already counted
// RUN    | counting kdone until the job length is reached
// FINISH | evt_done_o high; may pop the next job straight away
module multi_dataflow_job_sequencer
  import multi_dataflow_job_sequencer_pkg::*;
#(
  parameter int unsigned JOB_DEPTH = JOB_DEPTH_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned ID_W      = ID_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  multi_dataflow_job_sequencer_if.slave job,
  output logic                       start_o,
  input  logic                       kdone_i,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           out_cnt_o,
  output logic                       evt_done_o,
  output logic [ID_W-1:0]            done_id_o,
  output logic [$clog2(JOB_DEPTH):0] queue_lvl_o
);
  seq_state_e             state_q;
  logic [ID_W-1:0]        cur_id_q;
  logic [CNT_W-1:0]       cur_len_q;
  logic [ID_W+CNT_W-1:0]  head;
  logic [ID_W-1:0]        head_id;
  logic [CNT_W-1:0]       head_len;
  logic                   fifo_full, fifo_empty, push, pop, rdy_q;

  // rdy_q keeps job_ready_o low during reset and for the first cycle after.
  assign job.job_ready = rdy_q & ~fifo_full;
  assign push          = job.job_valid & job.job_ready;
  assign pop           = ~clear_i & ~fifo_empty & (state_q == IDLE || state_q == FINISH);
  assign head_id       = head[ID_W+CNT_W-1:CNT_W];
  assign head_len      = head[CNT_W-1:0];
  assign busy_o        = (state_q != IDLE) | ~fifo_empty;

  multi_dataflow_job_fifo #(
    .DEPTH  (JOB_DEPTH),
    .DATA_W (ID_W + CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  ({job.job_id, job.job_len}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (queue_lvl_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      cur_len_q  <= '0;
      out_cnt_o  <= '0;
      start_o    <= 1'b0;
      evt_done_o <= 1'b0;
      done_id_o  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      start_o    <= 1'b0;
      evt_done_o <= 1'b0;
      if (clear_i) begin
        state_q   <= IDLE;
        out_cnt_o <= '0;
      end else begin
        case (state_q)
          IDLE, FINISH: begin
            if (pop) begin
              cur_id_q  <= head_id;
              cur_len_q <= head_len;
              out_cnt_o <= '0;
              if (head_len == '0) begin
                state_q    <= FINISH;
                evt_done_o <= 1'b1;
                done_id_o  <= head_id;
              end else begin
                state_q <= START;
                start_o <= 1'b1;
              end
            end else begin
              state_q <= IDLE;
            end
          end
          START, RUN: begin
            state_q <= RUN;
            if (kdone_i) begin
              if (out_cnt_o != cur_len_q) out_cnt_o <= out_cnt_o + 1'b1;
              // A single-output job can finish on a kdone seen during START.
              if (out_cnt_o == cur_len_q - 1'b1) begin
                state_q    <= FINISH;
                evt_done_o <= 1'b1;
                done_id_o  <= cur_id_q;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_dataflow_job_sequencer.sv
module tb_multi_dataflow_job_sequencer;
  import multi_dataflow_job_sequencer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        start_o;
  logic        kdone_i;
  logic        busy_o;
  logic [15:0] out_cnt_o;
  logic        evt_done_o;
  logic [3:0]  done_id_o;
  logic [2:0]  queue_lvl_o;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_evt = 0;

  multi_dataflow_job_sequencer_if #(.ID_W(4), .CNT_W(16)) job_if ();

  multi_dataflow_job_sequencer #(.JOB_DEPTH(4), .CNT_W(16), .ID_W(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .job         (job_if),
    .start_o     (start_o),
    .kdone_i     (kdone_i),
    .busy_o      (busy_o),
    .out_cnt_o   (out_cnt_o),
    .evt_done_o  (evt_done_o),
    .done_id_o   (done_id_o),
    .queue_lvl_o (queue_lvl_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (start_o)    n_start++;
    if (evt_done_o) n_evt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_job(input logic [3:0] id, input logic [15:0] len);
    check_val("push_ready", job_if.job_ready, 1);
    job_if.job_valid = 1'b1;
    job_if.job_id    = id;
    job_if.job_len   = len;
    tick();
    job_if.job_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20 && !start_o; i++) tick();
    check_val(tag, start_o, 1);
  endtask

  // One job id=3 len=4, kdone pulses spaced three cycles apart.
  task automatic run_case1();
    int s0;
    s0 = n_start;
    push_job(4'd3, 16'd4);
    wait_start("c1_start");
    tick();
    for (int k = 0; k < 4; k++) begin
      kdone_i = 1'b1;
      tick();
      kdone_i = 1'b0;
      if (k < 3) begin
        check_val("c1_no_evt_early", evt_done_o, 0);
        tick();
        tick();
      end
    end
    check_val("c1_evt", evt_done_o, 1);
    check_val("c1_done_id", done_id_o, 3);
    check_val("c1_out_cnt", out_cnt_o, 4);
    tick();
    check_val("c1_evt_one_cycle", evt_done_o, 0);
    check_val("c1_idle_busy", busy_o, 0);
    check_val("c1_out_cnt_hold", out_cnt_o, 4);
    check_val("c1_one_start", n_start - s0, 1);
  endtask

  job_desc_t exp_q[$];
  job_desc_t jd;
  int        pending;
  int        e0;
  int        s0;

  initial begin
    rst_ni = 1'b0;
    clear_i = 1'b0;
    kdone_i = 1'b0;
    job_if.job_valid = 1'b0;
    job_if.job_id = '0;
    job_if.job_len = '0;
    tick();
    tick();
    check_val("rst_ready", job_if.job_ready, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_lvl", queue_lvl_o, 0);
    check_val("rst_start", start_o, 0);
    rst_ni = 1'b1;
    check_val("rel_ready_low", job_if.job_ready, 0);
    tick();
    check_val("rel_ready_high", job_if.job_ready, 1);

    run_case1();

    // Fill the queue while job 8 is running; a sixth job must wait.
    for (int j = 0; j < 5; j++) begin
      job_if.job_valid = 1'b1;
      job_if.job_id    = 4'(8 + j);
      job_if.job_len   = 16'd5;
      tick();
    end
    check_val("c2_full_ready", job_if.job_ready, 0);
    check_val("c2_full_lvl", queue_lvl_o, 4);
    job_if.job_id = 4'd13;
    repeat (3) tick();
    check_val("c2_held_lvl", queue_lvl_o, 4);
    check_val("c2_busy", busy_o, 1);
    kdone_i = 1'b1;
    repeat (5) tick();
    kdone_i = 1'b0;
    check_val("c2_evt", evt_done_o, 1);
    check_val("c2_done_id", done_id_o, 8);
    for (int i = 0; i < 10 && !job_if.job_ready; i++) tick();
    check_val("c2_ready_again", job_if.job_ready, 1);
    tick();
    job_if.job_valid = 1'b0;
    check_val("c2_lvl_after", queue_lvl_o, 4);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check_val("c2_clr_lvl", queue_lvl_o, 0);
    check_val("c2_clr_busy", busy_o, 0);

    // Zero-length job completes without a start pulse.
    s0 = n_start;
    push_job(4'd1, 16'd0);
    push_job(4'd2, 16'd2);
    check_val("c3_evt0", evt_done_o, 1);
    check_val("c3_id0", done_id_o, 1);
    check_val("c3_no_start0", start_o, 0);
    tick();
    check_val("c3_start", start_o, 1);
    check_val("c3_no_evt", evt_done_o, 0);
    tick();
    kdone_i = 1'b1;
    tick();
    tick();
    kdone_i = 1'b0;
    check_val("c3_evt1", evt_done_o, 1);
    check_val("c3_id1", done_id_o, 2);
    check_val("c3_cnt1", out_cnt_o, 2);
    tick();
    check_val("c3_one_start", n_start - s0, 1);

    // Clear during RUN aborts silently; late kdone ignored.
    e0 = n_evt;
    push_job(4'd5, 16'd3);
    wait_start("c4_start");
    tick();
    kdone_i = 1'b1;
    tick();
    kdone_i = 1'b0;
    check_val("c4_cnt_before", out_cnt_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check_val("c4_busy", busy_o, 0);
    check_val("c4_cnt_clr", out_cnt_o, 0);
    kdone_i = 1'b1;
    tick();
    kdone_i = 1'b0;
    tick();
    check_val("c4_stray_cnt", out_cnt_o, 0);
    check_val("c4_no_evt", n_evt - e0, 0);
    push_job(4'd6, 16'd1);
    wait_start("c4_new_start");
    tick();
    kdone_i = 1'b1;
    tick();
    kdone_i = 1'b0;
    check_val("c4_new_evt", evt_done_o, 1);
    check_val("c4_new_id", done_id_o, 6);
    check_val("c4_new_cnt", out_cnt_o, 1);
    tick();

    // kdone in IDLE ignored; kdone during START counted.
    kdone_i = 1'b1;
    tick();
    kdone_i = 1'b0;
    check_val("c5_idle_cnt", out_cnt_o, 1);
    push_job(4'd7, 16'd2);
    kdone_i = 1'b1;
    tick();
    check_val("c5_start", start_o, 1);
    check_val("c5_load_cnt", out_cnt_o, 0);
    tick();
    kdone_i = 1'b0;
    check_val("c5_start_counted", out_cnt_o, 1);
    check_val("c5_no_evt", evt_done_o, 0);
    tick();
    kdone_i = 1'b1;
    tick();
    kdone_i = 1'b0;
    check_val("c5_evt", evt_done_o, 1);
    check_val("c5_id", done_id_o, 7);
    check_val("c5_cnt", out_cnt_o, 2);
    tick();

    // Reset mid-RUN.
    push_job(4'd9, 16'd4);
    wait_start("c6_start");
    tick();
    kdone_i = 1'b1;
    tick();
    kdone_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check_val("c6_rst_busy", busy_o, 0);
    check_val("c6_rst_cnt", out_cnt_o, 0);
    check_val("c6_rst_id", done_id_o, 0);
    check_val("c6_rst_evt", evt_done_o, 0);
    check_val("c6_rst_start", start_o, 0);
    check_val("c6_rst_lvl", queue_lvl_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    check_val("c6_rel_ready", job_if.job_ready, 0);
    tick();
    check_val("c6_ready", job_if.job_ready, 1);
    run_case1();

    // Randomized traffic against a job-order scoreboard; the bench acts as
    // the kernel, returning exactly len done pulses after each start.
    pending = 0;
    for (int c = 0; c < 1200; c++) begin
      if (evt_done_o) begin
        check_val("rnd_evt_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check_val("rnd_done_id", done_id_o, exp_q[0].id);
          check_val("rnd_out_cnt", out_cnt_o, exp_q[0].len);
          check_val("rnd_pending", pending, 0);
          void'(exp_q.pop_front());
        end
      end
      if (start_o) begin
        check_val("rnd_start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check_val("rnd_start_len_nz", exp_q[0].len != 0, 1);
          pending = exp_q[0].len;
        end
      end
      kdone_i = 1'b0;
      if (pending > 0 && $urandom_range(0, 1) == 1) begin
        kdone_i = 1'b1;
        pending--;
      end
      job_if.job_valid = 1'b0;
      if (c < 500 && $urandom_range(0, 2) == 0) begin
        jd.id  = 4'($urandom_range(0, 15));
        jd.len = 16'($urandom_range(0, 6));
        job_if.job_valid = 1'b1;
        job_if.job_id    = jd.id;
        job_if.job_len   = jd.len;
        if (job_if.job_ready) exp_q.push_back(jd);
      end
      tick();
    end
    kdone_i = 1'b0;
    job_if.job_valid = 1'b0;
    tick();
    check_val("rnd_drained", exp_q.size(), 0);
    check_val("rnd_idle_busy", busy_o, 0);
    check_val("rnd_idle_lvl", queue_lvl_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
